// File: rtl/sid_pkg.sv
// Shared types and constants for the SID MAC scheduler: op order, FSM states,
// widths and the input snapshot layout.
package sid_pkg;

  localparam int VOICE_W       = 12;
  localparam int ENV_W         = 8;
  localparam int SAMP_W        = 16;
  localparam int VOL_W         = 4;
  localparam int NUM_VOICES    = 3;
  localparam int SCHED_LATENCY = 6;

  typedef enum logic [1:0] {OP_V0, OP_V1, OP_V2, OP_VOL} op_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [NUM_VOICES-1:0][VOICE_W-1:0] voice;
    logic [NUM_VOICES-1:0][ENV_W-1:0]   env;
    logic [SAMP_W-1:0]                  mix;
    logic [VOL_W-1:0]                   vol;
  } snap_t;

  // Offset-binary voice to signed, pre-scaled by 16 so AMP lands on product bits [23:8].
  function automatic logic [SAMP_W-1:0] voice_a(input logic [VOICE_W-1:0] v);
    return {~v[VOICE_W-1], v[VOICE_W-2:0], 4'b0000};
  endfunction

endpackage

// File: rtl/sid_mul16.sv
// Registered 16x16 multiply, signed A by unsigned B, one cycle of latency.
module sid_mul16 (
  input  logic        clk_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic signed [31:0] a_s, b_s, prod;
  logic [31:0]        p_q;

  // |A*B| < 2^31, so the low 32 bits of the extended product are exact.
  assign a_s  = {{16{a_i[15]}}, a_i};
  assign b_s  = {16'b0, b_i};
  assign prod = a_s * b_s;

  always_ff @(posedge clk_i) p_q <= prod;

  assign p_o = p_q;

endmodule

// File: rtl/sid_mac_sched.sv
// Frame scheduler sharing one multiplier across three voice envelopes and the
// master volume; one-deep request queue with sticky overrun.
module sid_mac_sched
  import sid_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLKen,
  input  logic [VOICE_W-1:0] VOICE0,
  input  logic [VOICE_W-1:0] VOICE1,
  input  logic [VOICE_W-1:0] VOICE2,
  input  logic [ENV_W-1:0]   ENV0,
  input  logic [ENV_W-1:0]   ENV1,
  input  logic [ENV_W-1:0]   ENV2,
  input  logic [SAMP_W-1:0]  MIX,
  input  logic [VOL_W-1:0]   VOL,
  output logic [SAMP_W-1:0]  AMP0,
  output logic [SAMP_W-1:0]  AMP1,
  output logic [SAMP_W-1:0]  AMP2,
  output logic [SAMP_W-1:0]  OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVERRUN
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  snap_t  snap_q, snap_d, snap_in;
  logic   pend_q, pend_d, ovr_q, ovr_d;
  logic   start;

  // Tracks which op's product sits in the multiplier register this cycle.
  logic   wb_vld_q;
  op_e    wb_op_q;

  logic [NUM_VOICES-1:0][SAMP_W-1:0] amp_q;
  logic [SAMP_W-1:0]                 out_q;
  logic [SAMP_W-1:0]                 mul_a, mul_b;
  logic [31:0]                       mul_p;
  logic                              unused_mul_bits;

  always_comb begin
    snap_in          = '0;
    snap_in.voice[0] = VOICE0;
    snap_in.voice[1] = VOICE1;
    snap_in.voice[2] = VOICE2;
    snap_in.env[0]   = ENV0;
    snap_in.env[1]   = ENV1;
    snap_in.env[2]   = ENV2;
    snap_in.mix      = MIX;
    snap_in.vol      = VOL;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A request queued in the DONE cycle is launched here; a new one joins the queue.
        start  = CLKen | pend_q;
        pend_d = CLKen & pend_q;
      end
      S_ISSUE: begin
        if (op_q == OP_VOL) state_d = S_DRAIN;
        else                op_d    = op_e'(op_q + 2'd1);
        if (CLKen) begin
          if (pend_q) ovr_d  = 1'b1;
          else        pend_d = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        if (CLKen) begin
          if (pend_q) ovr_d  = 1'b1;
          else        pend_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        start   = pend_q;
        pend_d  = CLKen & ~pend_q;
        if (CLKen & pend_q) ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_ISSUE;
      op_d    = OP_V0;
      snap_d  = snap_in;
    end
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (op_q)
      OP_V0: begin
        mul_a = voice_a(snap_q.voice[0]);
        mul_b = {{(SAMP_W-ENV_W){1'b0}}, snap_q.env[0]};
      end
      OP_V1: begin
        mul_a = voice_a(snap_q.voice[1]);
        mul_b = {{(SAMP_W-ENV_W){1'b0}}, snap_q.env[1]};
      end
      OP_V2: begin
        mul_a = voice_a(snap_q.voice[2]);
        mul_b = {{(SAMP_W-ENV_W){1'b0}}, snap_q.env[2]};
      end
      OP_VOL: begin
        mul_a = snap_q.mix;
        mul_b = {{(SAMP_W-VOL_W){1'b0}}, snap_q.vol};
      end
      default: ;
    endcase
  end

  sid_mul16 u_mul (
    .clk_i (CLK),
    .a_i   (mul_a),
    .b_i   (mul_b),
    .p_o   (mul_p)
  );

  assign unused_mul_bits = ^{mul_p[31:24], mul_p[3:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= OP_V0;
      snap_q   <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wb_vld_q <= 1'b0;
      wb_op_q  <= OP_V0;
      amp_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      snap_q   <= snap_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      wb_vld_q <= (state_q == S_ISSUE);
      wb_op_q  <= op_q;
      if (wb_vld_q) begin
        case (wb_op_q)
          OP_V0:   amp_q[0] <= mul_p[23:8];
          OP_V1:   amp_q[1] <= mul_p[23:8];
          OP_V2:   amp_q[2] <= mul_p[23:8];
          OP_VOL:  out_q    <= mul_p[19:4];
          default: ;
        endcase
      end
    end
  end

  assign AMP0    = amp_q[0];
  assign AMP1    = amp_q[1];
  assign AMP2    = amp_q[2];
  assign OUT     = out_q;
  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = (state_q == S_DONE);
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_sid_mac_sched.sv
// Directed corner frames, then random traffic, against a frame-level model.
module tb_sid_mac_sched;
  import sid_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLKen = 1'b0;
  logic [11:0] VOICE0 = '0, VOICE1 = '0, VOICE2 = '0;
  logic [7:0]  ENV0 = '0, ENV1 = '0, ENV2 = '0;
  logic [15:0] MIX = '0;
  logic [3:0]  VOL = '0;
  logic [15:0] AMP0, AMP1, AMP2, OUT;
  logic        BUSY, DONE, OVERRUN;

  sid_mac_sched dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen),
    .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
    .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
    .MIX(MIX), .VOL(VOL),
    .AMP0(AMP0), .AMP1(AMP1), .AMP2(AMP2), .OUT(OUT),
    .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;
  int cyc = 0;

  // Values to drive in the next cycle.
  logic [11:0] n_voice [3];
  logic [7:0]  n_env [3];
  logic [15:0] n_mix;
  logic [3:0]  n_vol;

  // Frame-level reference state.
  bit m_have, m_pend, m_ovr;
  int m_ft;
  int m_sv [3], m_env [3], m_mix, m_vol;
  int e_amp [3], e_out;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int fdiv16(input int p);
    return (p >= 0) ? p / 16 : -((-p + 15) / 16);
  endfunction

  task automatic snapshot();
    m_sv[0] = int'(VOICE0) - 2048; m_env[0] = int'(ENV0);
    m_sv[1] = int'(VOICE1) - 2048; m_env[1] = int'(ENV1);
    m_sv[2] = int'(VOICE2) - 2048; m_env[2] = int'(ENV2);
    m_mix   = int'($signed(MIX));
    m_vol   = int'(VOL);
    m_ft    = cyc;
    m_have  = 1'b1;
  endtask

  task automatic model_cycle();
    bit active;
    for (int k = 0; k < 4; k++)
      if (m_have && cyc == m_ft + 3 + k) begin
        if (k < 3) e_amp[k] = fdiv16(m_sv[k] * m_env[k]);
        else       e_out    = fdiv16(m_mix * m_vol);
      end
    active = m_have && cyc >= m_ft + 1 && cyc <= m_ft + SCHED_LATENCY;
    chk("amp0", AMP0, 16'(e_amp[0]));
    chk("amp1", AMP1, 16'(e_amp[1]));
    chk("amp2", AMP2, 16'(e_amp[2]));
    chk("out", OUT, 16'(e_out));
    chk("busy", {15'b0, BUSY}, {15'b0, active});
    chk("done", {15'b0, DONE}, {15'b0, active && cyc == m_ft + SCHED_LATENCY});
    chk("overrun", {15'b0, OVERRUN}, {15'b0, m_ovr});
    if (RST) begin
      m_have = 0; m_pend = 0; m_ovr = 0;
      for (int k = 0; k < 3; k++) e_amp[k] = 0;
      e_out = 0;
    end else if (!active) begin
      if (CLKen || m_pend) snapshot();
      m_pend = CLKen && m_pend;
    end else if (cyc == m_ft + SCHED_LATENCY) begin
      if (m_pend) begin
        snapshot();
        if (CLKen) m_ovr = 1;
        m_pend = 0;
      end else if (CLKen) m_pend = 1;
    end else if (CLKen) begin
      if (m_pend) m_ovr = 1;
      else        m_pend = 1;
    end
  endtask

  task automatic step(input logic r, input logic ce);
    @(posedge CLK);
    #1;
    RST = r; CLKen = ce;
    VOICE0 = n_voice[0]; VOICE1 = n_voice[1]; VOICE2 = n_voice[2];
    ENV0 = n_env[0]; ENV1 = n_env[1]; ENV2 = n_env[2];
    MIX = n_mix; VOL = n_vol;
    #3;
    model_cycle();
    cyc++;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 3; k++) begin
      n_voice[k] = 12'($urandom_range(0, 4095));
      n_env[k]   = 8'($urandom_range(0, 255));
    end
    n_mix = 16'($urandom_range(0, 65535));
    n_vol = 4'($urandom_range(0, 15));
  endtask

  initial begin
    m_have = 0; m_pend = 0; m_ovr = 0; m_ft = 0;
    e_amp = '{0, 0, 0}; e_out = 0;
    n_voice = '{12'h0, 12'h0, 12'h0}; n_env = '{8'h0, 8'h0, 8'h0};
    n_mix = '0; n_vol = '0;
    repeat (2) @(posedge CLK);
    step(1, 0);
    step(0, 0);

    // Extreme operands: full-scale voices and max volume.
    n_voice = '{12'hFFF, 12'h000, 12'h800};
    n_env   = '{8'hFF, 8'h80, 8'hFF};
    n_mix = 16'h7FFF; n_vol = 4'hF;
    step(0, 1);
    for (int i = 1; i <= SCHED_LATENCY; i++) step(0, 0);
    chk("lat_done", {15'b0, DONE}, 16'd1);
    chk("d_amp0", AMP0, 16'h7F70);
    chk("d_amp1", AMP1, 16'hC000);
    chk("d_amp2", AMP2, 16'h0000);
    chk("d_out_max", OUT, 16'h77FF);
    step(0, 0);

    // Negative mix floors; inputs change mid-frame and must be ignored.
    n_mix = 16'hFFFF; n_vol = 4'h1;
    n_voice = '{12'h123, 12'hABC, 12'h7FF}; n_env = '{8'h10, 8'h01, 8'hFE};
    step(0, 1);
    step(0, 0);
    rand_inputs();
    step(0, 0);
    for (int i = 3; i <= SCHED_LATENCY; i++) step(0, 0);
    chk("d_out_floor", OUT, 16'hFFFF);
    step(0, 0);

    // Back-to-back with a queued request and a dropped one.
    rand_inputs();
    step(0, 1);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    for (int i = 4; i <= 2 * SCHED_LATENCY; i++) begin
      step(0, 0);
      if (i == SCHED_LATENCY) chk("b2b_done1", {15'b0, DONE}, 16'd1);
    end
    chk("b2b_done2", {15'b0, DONE}, 16'd1);
    chk("b2b_ovr", {15'b0, OVERRUN}, 16'd1);
    step(0, 0);

    // Reset mid-frame abandons it; the next frame is clean.
    rand_inputs();
    step(0, 1);
    step(0, 0);
    step(0, 0);
    step(1, 1);
    for (int i = 0; i < 8; i++) step(0, 0);
    chk("rst_ovr", {15'b0, OVERRUN}, 16'd0);
    chk("rst_amp0", AMP0, 16'h0000);
    rand_inputs();
    step(0, 1);
    for (int i = 1; i <= SCHED_LATENCY; i++) step(0, 0);
    chk("post_rst_done", {15'b0, DONE}, 16'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      step(logic'($urandom_range(0, 79) == 0), logic'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
